instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit feeding the Thumb decoder: requests 32-bit words from instruction memory, splits them into 16-bit halfwords, buffers them with their addresses and presents one `instruction`/`PC_out` pair per cycle to decode under a valid/ready handshake. Execute-stage branch redirects flush the buffer and restart fetch at the new target, including halfword-aligned targets.

## Interface
- `RESET_PC`, 32'h0000_0000, address of the first instruction after reset (halfword aligned)
- `DEPTH`, 4, halfword buffer entries; power of two, ≥ 4

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  word read request; held until `imem_ack`
- `imem_addr`  out  32  word address, bits[1:0] = 0, stable while `imem_req`
- `imem_ack`  in  1  transfer completes in the cycle `imem_req && imem_ack`
- `imem_rdata`  in  32  read data, valid with `imem_ack`; [15:0] at addr, [31:16] at addr+2
- `instruction`  out  16  head halfword; 0 when `instr_valid` = 0
- `PC_out`  out  32  address of `instruction`; 0 when `instr_valid` = 0
- `instr_valid`  out  1  buffer non-empty
- `instr_ready`  in  1  decode accepts; pop when `instr_valid && instr_ready`
- `redirect`  in  1  branch taken, one-cycle pulse from execute
- `redirect_pc`  in  32  branch target; bit0 ignored

## Operation
- Registers: `fetch_pc` (word aligned), `skip_low`, state, FIFO of {pc[31:0], instr[15:0]}.
- States: `IDLE` (no request), `REQ` (request outstanding, data kept), `DROP` (request outstanding, data discarded).
- `IDLE`→`REQ` when free entries (DEPTH − count) ≥ 2; `imem_addr = fetch_pc`.
- `REQ` on ack: push low half (pc = fetch_pc) unless `skip_low`, then high half (pc = fetch_pc+2); clear `skip_low`; `fetch_pc += 4` (wraps 32'hFFFF_FFFC→0); next state `REQ` if post-update free ≥ 2, else `IDLE`.
- `redirect`: FIFO flushed; `fetch_pc ← {redirect_pc[31:2],2'b00}`; `skip_low ← redirect_pc[1]`. From `REQ` with no ack this cycle → `DROP`; request stays asserted with old address until ack. `DROP` on ack → discard data, then issue at new `fetch_pc`.
- Simultaneous events: redirect beats ack and pop in the same cycle (ack data discarded, pop ignored, state → `IDLE`/`REQ` per new request rule). Redirect during `DROP`: update `fetch_pc`/`skip_low`, stay `DROP`.
- Pop and push in the same cycle allowed; count = count + pushed − popped.
- Free-space check uses registered count; FIFO never overflows.

## Timing
- Reset values: `imem_req` 0, `imem_addr` RESET_PC word-aligned, `instr_valid` 0, `instruction` 0, `PC_out` 0, state `IDLE`, `fetch_pc` = RESET_PC & ~3, `skip_low` = RESET_PC[1], FIFO empty.
- First `imem_req` in the first cycle after `reset` deasserts.
- Ack in cycle N → `instr_valid` with that data in N+1 (outputs driven from registered FIFO head).
- Redirect in cycle N → `instr_valid` = 0 in N+1; earliest new request N+1 (from `IDLE`/`REQ`) or the cycle after the old ack (from `DROP`).
- Zero-wait memory (ack same cycle as req) + `instr_ready` tied high: sustained 1 instruction/cycle.
- Reset mid-request: all state cleared immediately; a late ack arriving after reset is ignored (state `IDLE`).

## Structure
- Shared package `cpu_pkg`: `fetch_state_t` enum {IDLE, REQ, DROP}, `HALF_W` = 16, `ADDR_W` = 32, `fetch_entry_t` struct {pc, instr}.
- Sub-module `fetch_fifo`: synchronous FIFO, 0/1/2-entry push, 1-entry pop, synchronous flush, `count` output.

## Test plan
- Reset release, RESET_PC = 0, memory returns 32'h2003_4601 at 0 → `instruction` 16'h4601 PC 0, then 16'h2003 PC 2.
- Zero-wait memory, ready high, 8 words → 16 consecutive instructions, PCs 0..30 step 2, no gaps after first.
- `instr_ready` low for 10 cycles → count saturates at DEPTH, `imem_req` drops, no data lost when ready returns.
- Redirect to 32'h0000_0102 while idle → request addr 32'h100, only high half delivered with PC 32'h102.
- Redirect to 32'h200 while request to 32'h40 pending (ack 3 cycles later) → 32'h40 data discarded, next request 32'h200, first instruction PC 32'h200.
- Redirect, ack and pop in same cycle → buffer empty next cycle, ack data absent, no spurious `instr_valid`.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and widths for the instruction fetch path
package cpu_pkg;

  localparam int HALF_W = 16;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [HALF_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - halfword FIFO taking up to two pushes and one pop per cycle
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push_lo,
  input  fetch_entry_t           i_lo,
  input  logic                   i_push_hi,
  input  fetch_entry_t           i_hi,
  input  logic                   i_pop,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  fetch_entry_t     w_first;
  logic             w_any_push;
  logic             w_two_push;
  logic             w_do_pop;
  logic [PTR_W-1:0] w_wr_ptr_p1;
  logic [CNT_W-1:0] w_push_n;

  // A lone high half takes the first free slot, same as a lone low half.
  assign w_first     = i_push_lo ? i_lo : i_hi;
  assign w_any_push  = i_push_lo | i_push_hi;
  assign w_two_push  = i_push_lo & i_push_hi;
  assign w_do_pop    = i_pop && (r_count != '0);
  assign w_wr_ptr_p1 = r_wr_ptr + PTR_W'(1);
  assign w_push_n    = w_two_push ? CNT_W'(2) : (w_any_push ? CNT_W'(1) : '0);

  always_ff @(posedge clk) begin
    if (!i_flush && w_any_push) begin
      r_mem[r_wr_ptr] <= w_first;
      if (w_two_push) begin
        r_mem[w_wr_ptr_p1] <= i_hi;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + w_push_n - CNT_W'(w_do_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetches 32-bit words, splits them into halfwords and feeds decode
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [HALF_W-1:0] instruction,
  output logic [ADDR_W-1:0] PC_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int               CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] ROOM_MAX = CNT_W'(DEPTH - 2);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic              r_skip_low;
  logic              w_skip_nxt;
  logic [ADDR_W-1:0] r_drop_addr;
  logic [ADDR_W-1:0] w_drop_addr_nxt;

  logic              w_ack;
  logic              w_pop;
  logic              w_fill;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_fill_n;
  logic [CNT_W-1:0]  w_count_after;
  logic              w_room_now;
  logic              w_room_after;
  fetch_entry_t      w_lo;
  fetch_entry_t      w_hi;
  fetch_entry_t      w_head;
  logic              w_unused;

  assign w_unused = redirect_pc[0];

  assign w_ack       = imem_req & imem_ack;
  assign instr_valid = (w_count != '0);
  // A redirect squashes the pop: the flushed head was never consumed.
  assign w_pop       = instr_valid & instr_ready & ~redirect;
  assign w_fill      = (r_state == REQ) & w_ack & ~redirect;

  assign w_fill_n      = r_skip_low ? CNT_W'(1) : CNT_W'(2);
  assign w_count_after = w_count + w_fill_n - CNT_W'(w_pop);
  assign w_room_now    = (w_count <= ROOM_MAX);
  assign w_room_after  = (w_count_after <= ROOM_MAX);

  assign w_lo.pc    = r_fetch_pc;
  assign w_lo.instr = imem_rdata[15:0];
  assign w_hi.pc    = r_fetch_pc + ADDR_W'(2);
  assign w_hi.instr = imem_rdata[31:16];

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .i_flush   (redirect),
    .i_push_lo (w_fill & ~r_skip_low),
    .i_lo      (w_lo),
    .i_push_hi (w_fill),
    .i_hi      (w_hi),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_skip_nxt      = r_skip_low;
    w_drop_addr_nxt = r_drop_addr;

    unique case (r_state)
      IDLE: begin
        if (redirect || w_room_now) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          // The bus transfer cannot be cancelled, so hold the old address until it acks.
          if (!w_ack) begin
            w_state_nxt     = DROP;
            w_drop_addr_nxt = r_fetch_pc;
          end
        end else if (w_ack) begin
          w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(4);
          w_skip_nxt     = 1'b0;
          w_state_nxt    = w_room_after ? REQ : IDLE;
        end
      end
      DROP: begin
        if (w_ack) begin
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (redirect) begin
      w_fetch_pc_nxt = {redirect_pc[ADDR_W-1:2], 2'b00};
      w_skip_nxt     = redirect_pc[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_fetch_pc  <= {RESET_PC[ADDR_W-1:2], 2'b00};
      r_skip_low  <= RESET_PC[1];
      r_drop_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_skip_low  <= w_skip_nxt;
      r_drop_addr <= w_drop_addr_nxt;
    end
  end

  assign imem_req    = (r_state != IDLE);
  assign imem_addr   = (r_state == DROP) ? r_drop_addr : r_fetch_pc;
  assign instruction = instr_valid ? w_head.instr : '0;
  assign PC_out      = instr_valid ? w_head.pc : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [15:0] instruction;
  logic [31:0] PC_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ack_en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] hw(input logic [31:0] a);
    if (a == 32'h0) return 16'h4601;
    if (a == 32'h2) return 16'h2003;
    return a[15:0] ^ 16'hC3C3;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {hw(a + 32'd2), hw(a)};
  endfunction

  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = mem_word(imem_addr);

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .PC_out      (PC_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold_reset();
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ack_en      = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int wait_n;

    hold_reset();
    @(negedge clk);
    expect_eq("rst_req",   64'(imem_req),    64'h0);
    expect_eq("rst_addr",  64'(imem_addr),   64'h0);
    expect_eq("rst_valid", 64'(instr_valid), 64'h0);
    expect_eq("rst_instr", 64'(instruction), 64'h0);
    expect_eq("rst_pc",    64'(PC_out),      64'h0);

    // zero-wait memory, decode always ready
    ack_en      = 1'b1;
    instr_ready = 1'b1;
    reset       = 1'b1;
    @(negedge clk);
    expect_eq("t1_req",  64'(imem_req),  64'h1);
    expect_eq("t1_addr", 64'(imem_addr), 64'h0);
    wait_n = 0;
    @(negedge clk);
    while (!instr_valid && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    expect_eq("t1_instr0", 64'(instruction), 64'h4601);
    expect_eq("t1_pc0",    64'(PC_out),      64'h0);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      expect_eq($sformatf("t2_valid%0d", i), 64'(instr_valid), 64'h1);
      expect_eq($sformatf("t2_pc%0d", i),    64'(PC_out),      64'(2 * i));
      expect_eq($sformatf("t2_instr%0d", i), 64'(instruction), 64'(hw(32'(2 * i))));
    end

    // decode stalls: buffer fills, fetch stops, nothing lost
    hold_reset();
    ack_en = 1'b1;
    reset  = 1'b1;
    repeat (10) @(negedge clk);
    expect_eq("t3_req_off", 64'(imem_req),    64'h0);
    expect_eq("t3_full",    64'(dut.w_count), 64'h4);
    expect_eq("t3_valid",   64'(instr_valid), 64'h1);
    instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      expect_eq($sformatf("t3_valid%0d", i), 64'(instr_valid), 64'h1);
      expect_eq($sformatf("t3_pc%0d", i),    64'(PC_out),      64'(2 * i));
    end

    // halfword-aligned redirect while idle
    hold_reset();
    ack_en      = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    reset       = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    expect_eq("t4_req",   64'(imem_req),    64'h1);
    expect_eq("t4_addr",  64'(imem_addr),   64'h100);
    expect_eq("t4_empty", 64'(instr_valid), 64'h0);
    @(negedge clk);
    expect_eq("t4_valid", 64'(instr_valid), 64'h1);
    expect_eq("t4_pc",    64'(PC_out),      64'h102);
    expect_eq("t4_instr", 64'(instruction), 64'(hw(32'h102)));
    instr_ready = 1'b1;
    @(negedge clk);
    expect_eq("t4_pc_next",    64'(PC_out),      64'h104);
    expect_eq("t4_instr_next", 64'(instruction), 64'(hw(32'h104)));

    // redirect while a request is pending: old data discarded
    hold_reset();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    reset       = 1'b1;
    @(negedge clk);
    expect_eq("t5_addr_old", 64'(imem_addr), 64'h40);
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    expect_eq("t5_req_hold",  64'(imem_req),    64'h1);
    expect_eq("t5_addr_hold", 64'(imem_addr),   64'h40);
    expect_eq("t5_empty",     64'(instr_valid), 64'h0);
    @(negedge clk);
    expect_eq("t5_addr_hold2", 64'(imem_addr), 64'h40);
    ack_en = 1'b1;
    @(negedge clk);
    expect_eq("t5_dropped", 64'(instr_valid), 64'h0);
    expect_eq("t5_req_new", 64'(imem_req),    64'h1);
    expect_eq("t5_addr_new", 64'(imem_addr),  64'h200);
    @(negedge clk);
    expect_eq("t5_valid", 64'(instr_valid), 64'h1);
    expect_eq("t5_pc",    64'(PC_out),      64'h200);
    expect_eq("t5_instr", 64'(instruction), 64'(hw(32'h200)));

    // redirect, ack and pop in the same cycle
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clk);
    redirect    = 1'b0;
    ack_en      = 1'b0;
    instr_ready = 1'b0;
    expect_eq("t6_valid", 64'(instr_valid), 64'h0);
    expect_eq("t6_instr", 64'(instruction), 64'h0);
    expect_eq("t6_pc",    64'(PC_out),      64'h0);
    expect_eq("t6_req",   64'(imem_req),    64'h1);
    expect_eq("t6_addr",  64'(imem_addr),   64'h300);
    @(negedge clk);
    expect_eq("t6_still_empty", 64'(instr_valid), 64'h0);

    // asynchronous reset mid-request
    reset = 1'b0;
    #1;
    expect_eq("t7_req",  64'(imem_req),  64'h0);
    expect_eq("t7_addr", 64'(imem_addr), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
